hopper_pulse_conditioner: RTL and testbench

//   Upstream stage of the bottling controller. Cleans the raw hopper drop sensor into one-cycle pill

---
 rtl/hopper_pulse_conditioner_pkg.sv | 27 ++
 rtl/hopper_pulse_conditioner_debounce_filter.sv | 59 +++++
 rtl/hopper_pulse_conditioner.sv | 164 ++++++++++++++++
 tb/tb_hopper_pulse_conditioner.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hopper_pulse_conditioner_pkg.sv
// Package: pill_defs
//   Definitions shared by the hopper pulse conditioner and the bottling
//   controller: watchdog FSM state encoding, BCD digit geometry and the
//   default debounce / watchdog timing constants.
package pill_defs;

  // Watchdog FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    STARVED = 2'd2
  } wd_state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam int         BCD_DIGITS    = 3;
  localparam int         BCD_COUNT_W   = BCD_DIGITS * BCD_DIGIT_W;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam int DEFAULT_DEBOUNCE_MS = 8;
  localparam int DEFAULT_TIMEOUT_MS  = 5000;

  // Increment one BCD digit; 9 rolls over to 0 (carry handled by the caller)
  function automatic logic [BCD_DIGIT_W-1:0] bcd_digit_inc(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= BCD_MAX_DIGIT) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/hopper_pulse_conditioner_debounce_filter.sv
// Module: debounce_filter
//   Two-flop synchronizer followed by a level debouncer for the hopper drop
//   sensor. A new level is accepted once the synchronized input has differed
//   from the current level for DEBOUNCE_MS consecutive clk_1khz samples.
// Ports:
//   clk_1khz      in   sole clock
//   rst           in   synchronous active-high reset
//   sensor_raw    in   asynchronous raw sensor
//   sensor_level  out  debounced level
//   glitch_abort  out  strobe: a partially-counted change was abandoned this cycle
module debounce_filter
  import pill_defs::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic sensor_raw,
  output logic sensor_level,
  output logic glitch_abort
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= sensor_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        // This sample completes the run: accept the level on the same edge
        // the count would reach DEBOUNCE_MS.
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  // Input fell back to the accepted level while a change was being counted.
  assign glitch_abort = (sync2_reg == level_reg) && (cnt_reg != '0);
  assign sensor_level = level_reg;

endmodule

// File: rtl/hopper_pulse_conditioner.sv
// Module: hopper_pulse_conditioner
//   Turns the raw hopper drop sensor into one-cycle pill pulses, keeps a
//   3-digit BCD pill count for the current bottle and runs a no-pill watchdog.
// Parameters:
//   DEBOUNCE_MS  samples a new sensor level must hold before acceptance (>=1)
//   TIMEOUT_MS   cycles without a pill, while enabled, before starved (>=2)
// Ports:
//   clk_1khz        in   sole clock (1 kHz)
//   rst             in   synchronous active-high reset
//   enable          in   controller RUNNING; gates pulses and the watchdog
//   count_clr       in   zero the pill count (bottle change)
//   sensor_raw      in   asynchronous hopper drop sensor
//   sensor_level    out  debounced sensor level
//   pill_pulse      out  one-cycle strobe per accepted pill
//   pill_count_bcd  out  {hundreds,tens,units} BCD count 000..999
//   starved         out  watchdog expired
//   glitch_cnt      out  rejected-glitch counter
// Build option:
//   HOPPER_GLITCH_CNT_EN  when defined, glitch_cnt counts rejected glitches
//                         (saturating at 255); otherwise it is tied to zero.
module hopper_pulse_conditioner
  import pill_defs::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
  parameter int TIMEOUT_MS  = DEFAULT_TIMEOUT_MS
) (
  input  logic                   clk_1khz,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   count_clr,
  input  logic                   sensor_raw,
  output logic                   sensor_level,
  output logic                   pill_pulse,
  output logic [BCD_COUNT_W-1:0] pill_count_bcd,
  output logic                   starved,
  output logic [7:0]             glitch_cnt
);

  localparam int              WD_W      = $clog2(TIMEOUT_MS + 1);
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_MS);

  logic glitch_abort;

  debounce_filter #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .clk_1khz     (clk_1khz),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .sensor_level (sensor_level),
    .glitch_abort (glitch_abort)
  );

  // Rising-edge pulse on the debounced level, qualified by enable
  logic level_d_reg;
  logic pill_pulse_reg;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      level_d_reg    <= 1'b0;
      pill_pulse_reg <= 1'b0;
    end else begin
      level_d_reg    <= sensor_level;
      pill_pulse_reg <= enable & sensor_level & ~level_d_reg;
    end
  end

  assign pill_pulse = pill_pulse_reg;

  // Watchdog FSM
  wd_state_t       state_reg;
  logic [WD_W-1:0] wd_reg;
  logic            starved_reg;

  always_ff @(posedge clk_1khz) begin
    if (rst || !enable) begin
      state_reg   <= IDLE;
      wd_reg      <= WD_RELOAD;
      starved_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg   <= WATCH;
          wd_reg      <= WD_RELOAD;
          starved_reg <= 1'b0;
        end
        WATCH: begin
          if (pill_pulse_reg) begin
            wd_reg <= WD_RELOAD;
          end else if (wd_reg == '0) begin
            state_reg   <= STARVED;
            starved_reg <= 1'b1;
          end else begin
            wd_reg <= wd_reg - 1'b1;
          end
        end
        STARVED: begin
          if (pill_pulse_reg) begin
            state_reg   <= WATCH;
            wd_reg      <= WD_RELOAD;
            starved_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          wd_reg      <= WD_RELOAD;
          starved_reg <= 1'b0;
        end
      endcase
    end
  end

  assign starved = starved_reg;

  // BCD pill counter: ripple carry across digits, 999 wraps to 000
  logic [BCD_COUNT_W-1:0] count_reg;
  logic [BCD_COUNT_W-1:0] count_inc;
  logic [BCD_DIGITS-1:0]  carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      logic [BCD_DIGIT_W-1:0] digit;
      assign digit = count_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
      assign count_inc[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = carry[gi] ? bcd_digit_inc(digit) : digit;
      if (gi < BCD_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & (digit == BCD_MAX_DIGIT);
      end
    end
  endgenerate

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      count_reg <= '0;
    end else if (count_clr) begin
      // A pill arriving with the clear belongs to the new bottle
      count_reg <= pill_pulse_reg ? BCD_COUNT_W'(1) : '0;
    end else if (pill_pulse_reg) begin
      count_reg <= count_inc;
    end
  end

  assign pill_count_bcd = count_reg;

`ifdef HOPPER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_reg;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      glitch_cnt_reg <= 8'd0;
    end else if (glitch_abort && (glitch_cnt_reg != 8'hFF)) begin
      glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_reg;
`else
  logic unused_glitch_abort;
  assign unused_glitch_abort = glitch_abort;
  assign glitch_cnt          = 8'd0;
`endif

endmodule

// File: tb/tb_hopper_pulse_conditioner.sv
// Testbench for hopper_pulse_conditioner (default parameters).
module tb_hopper_pulse_conditioner;

  localparam int DEB = 8;
  localparam int TMO = 5000;

  logic        clk_1khz;
  logic        rst;
  logic        enable;
  logic        count_clr;
  logic        sensor_raw;
  logic        sensor_level;
  logic        pill_pulse;
  logic [11:0] pill_count_bcd;
  logic        starved;
  logic [7:0]  glitch_cnt;

  hopper_pulse_conditioner #(
    .DEBOUNCE_MS (DEB),
    .TIMEOUT_MS  (TMO)
  ) dut (
    .clk_1khz       (clk_1khz),
    .rst            (rst),
    .enable         (enable),
    .count_clr      (count_clr),
    .sensor_raw     (sensor_raw),
    .sensor_level   (sensor_level),
    .pill_pulse     (pill_pulse),
    .pill_count_bcd (pill_count_bcd),
    .starved        (starved),
    .glitch_cnt     (glitch_cnt)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [22:0] dut_vec;
  assign dut_vec = {sensor_level, pill_pulse, starved, pill_count_bcd, glitch_cnt};

  // Reference model state, advanced once per clock edge
  bit raw_hist[$];
  bit s2_hist[$];
  bit m_level, m_level_d, m_pulse, m_starved, m_running;
  int m_quiet, m_count, m_glitch;

  task automatic model_edge();
    bit s2;
    bit new_level;
    bit new_pulse;
    bit all_diff;
    if (rst) begin
      raw_hist.delete();
      s2_hist.delete();
      m_level = 0; m_level_d = 0; m_pulse = 0; m_starved = 0; m_running = 0;
      m_quiet = 0; m_count = 0; m_glitch = 0;
      return;
    end
    // Logic sees the raw input as sampled two edges earlier
    s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
    raw_hist.push_back(sensor_raw);
    if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    // A run of differing samples shorter than DEB ending on the old level is a glitch
    if (s2 == m_level && s2_hist.size() > 0 && s2_hist[s2_hist.size()-1] != m_level)
      if (m_glitch < 255) m_glitch++;
    s2_hist.push_back(s2);
    if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
    new_level = m_level;
    if (s2_hist.size() == DEB) begin
      all_diff = 1;
      foreach (s2_hist[i]) if (s2_hist[i] == m_level) all_diff = 0;
      if (all_diff) begin
        new_level = s2;
        s2_hist.delete();
      end
    end
    new_pulse = enable && m_level && !m_level_d;
    m_level_d = m_level;
    m_level   = new_level;
    if (count_clr)    m_count = m_pulse ? 1 : 0;
    else if (m_pulse) m_count = (m_count + 1) % 1000;
    if (!enable) begin
      m_running = 0; m_starved = 0;
    end else if (!m_running) begin
      m_running = 1; m_quiet = 0; m_starved = 0;
    end else if (m_pulse) begin
      m_quiet = 0; m_starved = 0;
    end else if (!m_starved) begin
      if (m_quiet == TMO) m_starved = 1;
      else m_quiet++;
    end
    m_pulse = new_pulse;
  endtask

  function automatic logic [7:0] exp_glitch(input int g);
`ifdef HOPPER_GLITCH_CNT_EN
    return 8'(g);
`else
    return (g < 0) ? 8'd1 : 8'd0;
`endif
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [22:0] model_vec();
    return {m_level, m_pulse, m_starved, to_bcd(m_count), exp_glitch(m_glitch)};
  endfunction

  task automatic tick();
    @(posedge clk_1khz);
    model_edge();
    @(negedge clk_1khz);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; count_clr = 0; sensor_raw = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec !== 23'd0) begin
        errors++; $display("FAIL reset_state cyc %0d got %h expected %h", cyc, dut_vec, 23'd0);
      end
    end
    rst = 0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL reset_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      checks++;
      if (sensor_level !== (n >= 2 + DEB)) begin
        errors++; $display("FAIL level_latency edge %0d got %b expected %b", n, sensor_level, (n >= 2 + DEB));
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    sensor_raw = 0; enable = 1;
    for (int c = 0; c < 40; c++) begin
      if (c >= 15 && c < 20) sensor_raw = 1;
      else sensor_raw = 0;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL glitch_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      if (c >= 15 && (pill_pulse === 1'b1 || sensor_level !== 1'b0)) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL glitch_passed got %0d events expected 0", pulses);
    end
    checks++;
`ifdef HOPPER_GLITCH_CNT_EN
    if (glitch_cnt !== 8'd1) begin
      errors++; $display("FAIL glitch_cnt got %0d expected 1", glitch_cnt);
    end
`else
    if (glitch_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_cnt got %0d expected 0", glitch_cnt);
    end
`endif
  endtask

  task automatic test_pills();
    int pulses = 0;
    bit clr_done = 0;
    for (int p = 0; p < 12; p++) begin
      for (int c = 0; c < 20; c++) begin
        sensor_raw = (c < 10);
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL pills_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
        end
        if (pill_pulse === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses !== 12 || pill_count_bcd !== 12'h012) begin
      errors++; $display("FAIL twelve_pills got %0d pulses count %h expected 12 pulses count 012", pulses, pill_count_bcd);
    end
    for (int c = 0; c < 30; c++) begin
      sensor_raw = (c < 10);
      count_clr = 0;
      if (pill_pulse === 1'b1 && !clr_done) begin
        count_clr = 1;
        clr_done  = 1;
      end
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL clr_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
    end
    count_clr = 0;
    checks++;
    if (!clr_done || pill_count_bcd !== 12'h001) begin
      errors++; $display("FAIL clr_with_pulse got count %h pulse_seen %0d expected 001", pill_count_bcd, clr_done);
    end
  endtask

  task automatic test_bcd_wrap();
    count_clr = 1; sensor_raw = 0;
    tick();
    count_clr = 0;
    for (int p = 0; p < 1000; p++) begin
      for (int c = 0; c < 20; c++) begin
        sensor_raw = (c < 10);
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL wrap_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
        end
      end
      if (p == 997) begin
        checks++;
        if (pill_count_bcd !== 12'h998) begin
          errors++; $display("FAIL preload_998 got %h expected 998", pill_count_bcd);
        end
      end else if (p == 998) begin
        checks++;
        if (pill_count_bcd !== 12'h999) begin
          errors++; $display("FAIL count_999 got %h expected 999", pill_count_bcd);
        end
      end else if (p == 999) begin
        checks++;
        if (pill_count_bcd !== 12'h000) begin
          errors++; $display("FAIL wrap_000 got %h expected 000", pill_count_bcd);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int n = 0;
    int pulses = 0;
    bit seen = 0;
    logic was_pulse, was_starved;
    logic [11:0] saved_count;
    enable = 0; sensor_raw = 0;
    tick(); tick();
    enable = 1;
    for (int i = 0; i < TMO + 50 && !seen; i++) begin
      tick();
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL wd_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      if (starved === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n !== TMO + 2) begin
      errors++; $display("FAIL starve_time got %0d edges (seen %0d) expected %0d", n, seen, TMO + 2);
    end
    for (int c = 0; c < 40; c++) begin
      sensor_raw  = (c < 10);
      was_pulse   = pill_pulse;
      was_starved = starved;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL wd_pill_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      if (was_pulse === 1'b1) begin
        pulses++;
        checks++;
        if (was_starved !== 1'b1 || starved !== 1'b0) begin
          errors++; $display("FAIL starve_clear got %b->%b expected 1->0", was_starved, starved);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL starve_pill got %0d pulses expected 1", pulses);
    end
    enable = 0;
    saved_count = to_bcd(m_count);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      sensor_raw = (c >= 5 && c < 15);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL idle_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      if (pill_pulse === 1'b1 || starved !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0 || pill_count_bcd !== saved_count) begin
      errors++; $display("FAIL idle_no_pulse got %0d events count %h expected 0 events count %h", pulses, pill_count_bcd, saved_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int pulses = 0;
    bit seen = 0;
    count_clr = 1; sensor_raw = 0;
    tick();
    count_clr = 0; enable = 1;
    tick();
    for (int i = 0; i < TMO && m_quiet < TMO - 100 - 8; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL mid_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
    end
    sensor_raw = 1;
    for (int i = 0; i < 8; i++) tick();
    rst = 1; sensor_raw = 0;
    tick();
    checks++;
    if (dut_vec !== 23'd0) begin
      errors++; $display("FAIL mid_reset got %h expected %h", dut_vec, 23'd0);
    end
    rst = 0;
    for (int i = 0; i < TMO + 50 && !seen; i++) begin
      tick();
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL mid_after_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
      if (pill_pulse === 1'b1) pulses++;
      if (starved === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n !== TMO + 2 || pulses !== 0 || pill_count_bcd !== 12'h000) begin
      errors++; $display("FAIL mid_reload got %0d edges pulses %0d count %h expected %0d edges 0 pulses count 000", n, pulses, pill_count_bcd, TMO + 2);
    end
  endtask

  task automatic test_random();
    int seg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        sensor_raw = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 25);
      end
      seg--;
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      count_clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random_model cyc %0d got %h expected %h", cyc, dut_vec, model_vec());
      end
    end
    rst = 0; count_clr = 0;
  endtask

  initial begin
    rst = 1; enable = 0; count_clr = 0; sensor_raw = 0;
    test_reset();
    test_glitch();
    test_pills();
    test_bcd_wrap();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
